seg7_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment scan controller: drives NUM_DIGITS common-select digits from one shared segment bus.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller:
// blank pattern, hex-to-segment table and slot-phase encoding.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {BLANK, DRIVE} slot_phase_e;

    // Active-low pattern; bit7 is the decimal point and lights when dp=1
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib, input logic dp);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return {~dp, s};
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational {dp,nibble} to active-low 7-segment pattern for one digit.
// Only instantiated when SEG7_HEX_DECODE_EN is defined.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [4:0] DIGIT_IN,
    output logic [7:0] SEG_OUT
);

    assign SEG_OUT = hex_to_seg(DIGIT_IN[3:0], DIGIT_IN[4]);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blanking gap and frame-synchronous
// double-buffered update. Define SEG7_HEX_DECODE_EN to accept {dp,nibble} digits.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 32768,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    input  logic                                ENABLE,
`ifdef SEG7_HEX_DECODE_EN
    input  logic [5*NUM_DIGITS-1:0]             SEG_DATA,
`else
    input  logic [8*NUM_DIGITS-1:0]             SEG_DATA,
`endif
    input  logic                                LOAD,
    output logic                                PENDING,
    output logic                                FRAME_STRB,
    output logic [idx_width(NUM_DIGITS)-1:0]    DIGIT_IDX,
    output logic [7:0]                          SEG,
    output logic [NUM_DIGITS-1:0]               CS
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LEN = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || SCAN_DIV < 2 ||
        BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_param_check
        $fatal(1, "seg7_scan_ctrl: illegal NUM_DIGITS/SCAN_DIV/BLANK_CYCLES");
    end

    logic [NUM_DIGITS-1:0][7:0] din;

`ifdef SEG7_HEX_DECODE_EN
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        seg7_hex_decode u_dec (
            .DIGIT_IN (SEG_DATA[5*i +: 5]),
            .SEG_OUT  (din[i])
        );
    end
`else
    assign din = SEG_DATA;
`endif

    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       run_q;
    logic                       frame_start;
    logic [NUM_DIGITS-1:0][7:0] shadow_q, shadow_d, pbuf_q, pbuf_d;
    logic                       pending_q, pending_d;
    slot_phase_e                phase_d;
    logic [7:0]                 seg_d;
    logic [NUM_DIGITS-1:0]      cs_d;
    logic                       strb_d;

    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        frame_start = 1'b0;
        if (!ENABLE) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (!run_q) begin
            // First enabled cycle restarts the frame at digit 0
            cnt_d       = '0;
            idx_d       = '0;
            frame_start = 1'b1;
        end else if (cnt_q == SCAN_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d       = '0;
                frame_start = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Shadow only changes on a frame start, so a frame is never torn
        shadow_d  = shadow_q;
        pbuf_d    = pbuf_q;
        pending_d = pending_q;
        if (frame_start && LOAD) begin
            shadow_d  = din;
            pending_d = 1'b0;
        end else if (frame_start) begin
            if (pending_q)
                shadow_d = pbuf_q;
            pending_d = 1'b0;
        end else if (LOAD) begin
            pbuf_d    = din;
            pending_d = 1'b1;
        end

        phase_d = (ENABLE && cnt_d >= BLANK_LEN) ? DRIVE : BLANK;
        seg_d   = SEG_OFF;
        cs_d    = '1;
        if (phase_d == DRIVE) begin
            seg_d = shadow_d[idx_d];
            cs_d  = ~(NUM_DIGITS'(1) << idx_d);
        end
        strb_d = ENABLE && (cnt_d == '0) && (idx_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            run_q      <= 1'b0;
            shadow_q   <= {NUM_DIGITS{SEG_OFF}};
            pbuf_q     <= {NUM_DIGITS{SEG_OFF}};
            pending_q  <= 1'b0;
            SEG        <= SEG_OFF;
            CS         <= '1;
            FRAME_STRB <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            run_q      <= ENABLE;
            shadow_q   <= shadow_d;
            pbuf_q     <= pbuf_d;
            pending_q  <= pending_d;
            SEG        <= seg_d;
            CS         <= cs_d;
            FRAME_STRB <= strb_d;
        end
    end

    assign PENDING   = pending_q;
    assign DIGIT_IDX = idx_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// Also builds with SEG7_HEX_DECODE_EN, where the load vectors become {dp,nibble} digits.
module tb_seg7_scan_ctrl;

`ifdef SEG7_HEX_DECODE_EN
    localparam int DW = 20;
    localparam logic [DW-1:0] LD_A = {5'h03, 5'h02, 5'h01, 5'h00};
    localparam logic [DW-1:0] LD_B = {4{5'h01}};
    localparam logic [DW-1:0] LD_C = {4{5'h02}};
    localparam logic [DW-1:0] LD_D = {5'h1F, 5'h0E, 5'h00, 5'h1A};
    localparam logic [DW-1:0] LD_E = {5'h04, 5'h03, 5'h02, 5'h01};
    localparam logic [31:0]   EXP_C = 32'hA4A4A4A4;
`else
    localparam int DW = 32;
    localparam logic [DW-1:0] LD_A = 32'hB0A4F9C0;
    localparam logic [DW-1:0] LD_B = 32'h11111111;
    localparam logic [DW-1:0] LD_C = 32'h22222222;
    localparam logic [DW-1:0] LD_D = 32'h0E86C008;
    localparam logic [DW-1:0] LD_E = 32'h99B0A4F9;
    localparam logic [31:0]   EXP_C = 32'h22222222;
`endif
    localparam logic [31:0] EXP_A = 32'hB0A4F9C0;
    localparam logic [31:0] EXP_D = 32'h0E86C008;
    localparam logic [31:0] EXP_E = 32'h99B0A4F9;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          ENABLE = 1'b0;
    logic [DW-1:0] SEG_DATA = '0;
    logic          LOAD = 1'b0;
    logic          PENDING, FRAME_STRB;
    logic [1:0]    DIGIT_IDX;
    logic [7:0]    SEG;
    logic [3:0]    CS;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ENABLE     (ENABLE),
        .SEG_DATA   (SEG_DATA),
        .LOAD       (LOAD),
        .PENDING    (PENDING),
        .FRAME_STRB (FRAME_STRB),
        .DIGIT_IDX  (DIGIT_IDX),
        .SEG        (SEG),
        .CS         (CS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [3:0] cs;
        logic [7:0] seg;
        logic       strb;
        logic       pend;
        logic [1:0] idx;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Hand-maintained picture of what the display should show
    logic [31:0] disp = 32'hFFFFFFFF;
    logic        exp_pend = 1'b0;
    int          p = 0;
    bit          running = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ev);
        checks++;
        if (act !== ev) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, ev);
        end
    endtask

    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("CS",         32'(CS),         32'(e.cs));
            chk("SEG",        32'(SEG),        32'(e.seg));
            chk("FRAME_STRB", 32'(FRAME_STRB), 32'(e.strb));
            chk("PENDING",    32'(PENDING),    32'(e.pend));
            chk("DIGIT_IDX",  32'(DIGIT_IDX),  32'(e.idx));
        end
    end

    // One clock of stimulus; pushes the outputs expected right after this edge
    task automatic tick(input logic en, input logic ld, input logic [DW-1:0] d, input logic rn);
        exp_t e;
        int   dg, s;
        ENABLE   = en;
        LOAD     = ld;
        SEG_DATA = d;
        RST_N    = rn;
        @(posedge CLK);
        cyc++;
        e.cyc = cyc;
        if (!rn || !en) begin
            running = 0;
            e.cs = 4'hF; e.seg = 8'hFF; e.strb = 1'b0; e.idx = 2'd0;
        end else begin
            p       = running ? (p + 1) % 32 : 0;
            running = 1;
            dg      = p / 8;
            s       = p % 8;
            e.cs    = (s < 2) ? 4'hF : ~(4'b0001 << dg);
            e.seg   = (s < 2) ? 8'hFF : disp[dg*8 +: 8];
            e.strb  = (p == 0);
            e.idx   = 2'(dg);
        end
        e.pend = exp_pend;
        q.push_back(e);
        #1;
        LOAD = 1'b0;
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (p != target && guard < 64) begin
            tick(1'b1, 1'b0, '0, 1'b1);
            guard++;
        end
        if (p != target) begin
            errors++;
            $display("FAIL run_to position=%0d expected=%0d", p, target);
        end
    endtask

    initial begin
        // Reset held with ENABLE high
        repeat (3) tick(1'b1, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b1);
        run_to(31);
        run_to(31 - 1);
        run_to(31);
        tick(1'b1, 1'b0, '0, 1'b1);

        // Mid-frame load is held back until the next frame start
        run_to(10);
        exp_pend = 1'b1;
        tick(1'b1, 1'b1, LD_A, 1'b1);
        run_to(31);
        disp = EXP_A; exp_pend = 1'b0;
        tick(1'b1, 1'b0, '0, 1'b1);
        run_to(31);

        // Two loads in one frame: the later one wins
        tick(1'b1, 1'b0, '0, 1'b1);
        run_to(5);
        exp_pend = 1'b1;
        tick(1'b1, 1'b1, LD_B, 1'b1);
        run_to(20);
        tick(1'b1, 1'b1, LD_C, 1'b1);
        run_to(31);
        disp = EXP_C; exp_pend = 1'b0;
        tick(1'b1, 1'b0, '0, 1'b1);
        run_to(31);

        // Load on the frame-boundary edge goes straight to the display
        disp = EXP_D;
        tick(1'b1, 1'b1, LD_D, 1'b1);
        run_to(31);

        // Disable during digit 2 drive, load while disabled, re-enable
        tick(1'b1, 1'b0, '0, 1'b1);
        run_to(19);
        tick(1'b0, 1'b0, '0, 1'b1);
        exp_pend = 1'b1;
        tick(1'b0, 1'b1, LD_E, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        disp = EXP_E; exp_pend = 1'b0;
        tick(1'b1, 1'b0, '0, 1'b1);
        run_to(31);

        // Reset mid-drive wins over ENABLE and LOAD
        tick(1'b1, 1'b0, '0, 1'b1);
        run_to(5);
        disp = 32'hFFFFFFFF; exp_pend = 1'b0;
        tick(1'b1, 1'b1, LD_A, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b1);
        run_to(12);

        @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d expected=completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
